// File: rtl/key_loader_pkg.sv
// Purpose: shared types and helpers for the serial key loader.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package key_loader_pkg;

  // Width of the consecutive-failure counter; it saturates at its all-ones value.
  localparam int FAIL_CNT_W = 4;

  typedef enum logic [2:0] {
    KL_IDLE    = 3'd0,
    KL_SHIFT   = 3'd1,
    KL_CHECK   = 3'd2,
    KL_ARMED   = 3'd3,
    KL_ERROR   = 3'd4,
    KL_LOCKOUT = 3'd5
  } kl_state_t;

  // Serial bits in one frame: the key itself plus the trailing even-parity bit.
  function automatic int frame_bits(input int key_width);
    return key_width + 1;
  endfunction

endpackage

// File: rtl/key_shift_par.sv
// Purpose: LSB-first deserialiser with bit counter and running even parity.
// Latency: one edge per accepted bit; done is flagged combinationally on the final accept.
// Backpressure: none of its own; the parent gates accept with its ready/valid handshake.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   clear      - zero the shift register, counter and parity (new frame)
//   accept     - bit_in is consumed on this edge
//   bit_in     - serial data bit
//   done       - this accept is the last bit of the frame (the parity bit)
//   parity_ok  - XOR of every accepted bit so far is zero
//   data       - assembled key bits
module key_shift_par
  import key_loader_pkg::*;
#(
  parameter int KEY_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 accept,
  input  logic                 bit_in,
  output logic                 done,
  output logic                 parity_ok,
  output logic [KEY_WIDTH-1:0] data
);

  localparam int FRAME_BITS = frame_bits(KEY_WIDTH);
  localparam int CNT_W      = $clog2(KEY_WIDTH + 2);

  logic [CNT_W-1:0]     bit_cnt;
  logic [KEY_WIDTH-1:0] shift_q;
  logic                 par_q;

  // The parent must leave SHIFT on this same edge, so the flag cannot wait a cycle.
  assign done      = accept && (bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign parity_ok = ~par_q;
  assign data      = shift_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else if (accept && (bit_cnt < CNT_W'(FRAME_BITS))) begin
      // Decode the position explicitly: the counter is one bit wider than a
      // key index because it also has to count the parity bit.
      for (int i = 0; i < KEY_WIDTH; i++) begin
        if (bit_cnt == CNT_W'(i)) begin
          shift_q[i] <= bit_in;
        end
      end
      par_q   <= par_q ^ bit_in;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_loader.sv
// Purpose: receives a parity-protected serial key frame and drives the locked core's key bus.
// Latency: key_armed/key_err/locked_out update 2 edges after the parity-bit accept.
// Backpressure: sdi_ready is high only in SHIFT; bits offered at other times are dropped.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   frame_start   - one-cycle pulse that starts (or restarts) a frame
//   sdi/sdi_valid - serial key bit and its qualifier; sdi_ready accepts it
//   key_out       - parallel key, DECOY unless a verified key is held
//   key_armed     - key_out carries a verified key
//   key_err       - last frame failed parity
//   locked_out    - sticky lockout after MAX_TRIES consecutive bad frames
//   fail_cnt      - consecutive failed frames (saturating)
module key_loader
  import key_loader_pkg::*;
#(
  parameter int                   KEY_WIDTH = 16,
  parameter logic [KEY_WIDTH-1:0] DECOY     = '0,
  parameter int                   MAX_TRIES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  sdi,
  input  logic                  sdi_valid,
  output logic                  sdi_ready,
  output logic [KEY_WIDTH-1:0]  key_out,
  output logic                  key_armed,
  output logic                  key_err,
  output logic                  locked_out,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

  localparam logic [2:0] ST_IDLE    = KL_IDLE;
  localparam logic [2:0] ST_SHIFT   = KL_SHIFT;
  localparam logic [2:0] ST_CHECK   = KL_CHECK;
  localparam logic [2:0] ST_ARMED   = KL_ARMED;
  localparam logic [2:0] ST_ERROR   = KL_ERROR;
  localparam logic [2:0] ST_LOCKOUT = KL_LOCKOUT;

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic                  start_ok;
  logic                  accept;
  logic                  sp_done;
  logic                  sp_parity_ok;
  logic [KEY_WIDTH-1:0]  sp_data;
  logic [FAIL_CNT_W-1:0] fail_inc;

  // frame_start is honoured everywhere except CHECK and LOCKOUT.
  assign start_ok = frame_start &&
                    ((state_q == ST_IDLE)  || (state_q == ST_SHIFT) ||
                     (state_q == ST_ARMED) || (state_q == ST_ERROR));

  // A bit colliding with frame_start belongs to the aborted frame, so drop it.
  assign accept = (state_q == ST_SHIFT) && sdi_ready && sdi_valid && !frame_start;

  assign fail_inc = (fail_cnt == {FAIL_CNT_W{1'b1}}) ? fail_cnt : fail_cnt + 1'b1;

  key_shift_par #(
    .KEY_WIDTH (KEY_WIDTH)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .accept    (accept),
    .bit_in    (sdi),
    .done      (sp_done),
    .parity_ok (sp_parity_ok),
    .data      (sp_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ARMED, ST_ERROR: begin
        if (frame_start) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (frame_start)  state_d = ST_SHIFT;
        else if (sp_done) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (sp_parity_ok)                           state_d = ST_ARMED;
        else if (fail_inc == FAIL_CNT_W'(MAX_TRIES)) state_d = ST_LOCKOUT;
        else                                        state_d = ST_ERROR;
      end
      ST_LOCKOUT: state_d = ST_LOCKOUT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Every output is a flop decoded from the next state, so nothing reaches
  // the pins combinationally and flags change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sdi_ready  <= 1'b0;
      key_out    <= DECOY;
      key_armed  <= 1'b0;
      key_err    <= 1'b0;
      locked_out <= 1'b0;
      fail_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      sdi_ready  <= (state_d == ST_SHIFT);
      key_armed  <= (state_d == ST_ARMED);
      key_err    <= (state_d == ST_ERROR);
      locked_out <= (state_d == ST_LOCKOUT);

      // Load only on CHECK->ARMED; otherwise hold while armed, DECOY elsewhere,
      // so partial shift contents never appear on the key bus.
      if (state_d != ST_ARMED) begin
        key_out <= DECOY;
      end else if (state_q == ST_CHECK) begin
        key_out <= sp_data;
      end

      if (state_q == ST_CHECK) begin
        fail_cnt <= sp_parity_ok ? '0 : fail_inc;
      end
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Purpose: self-checking bench for key_loader with a frame-result scoreboard.
// Latency: checks the 2-edge parity-accept-to-result delay on every frame.
// Backpressure: honours sdi_ready and inserts random valid gaps.
module tb_key_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        sdi;
  logic        sdi_valid;
  logic        sdi_ready;
  logic [15:0] key_out;
  logic        key_armed;
  logic        key_err;
  logic        locked_out;
  logic [3:0]  fail_cnt;

  int n_chk = 0;
  int n_err = 0;
  int model_fail = 0;

  typedef struct {
    logic        armed;
    logic        err;
    logic        locked;
    logic [15:0] key;
    logic [3:0]  fail;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  key_loader #(
    .KEY_WIDTH (16),
    .DECOY     (16'h0000),
    .MAX_TRIES (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .sdi         (sdi),
    .sdi_valid   (sdi_valid),
    .sdi_ready   (sdi_ready),
    .key_out     (key_out),
    .key_armed   (key_armed),
    .key_err     (key_err),
    .locked_out  (locked_out),
    .fail_cnt    (fail_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_key_out"},    key_out,    32'h0);
    chk({tag, "_key_armed"},  key_armed,  32'h0);
    chk({tag, "_key_err"},    key_err,    32'h0);
    chk({tag, "_locked_out"}, locked_out, 32'h0);
    chk({tag, "_fail_cnt"},   fail_cnt,   32'h0);
    chk({tag, "_sdi_ready"},  sdi_ready,  32'h0);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Send the first n bits of the frame {par, key} LSB first.
  task automatic send_bits(input logic [15:0] key, input logic par, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int w;
      if (gaps) begin
        sdi_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      sdi       = (i < 16) ? key[i] : par;
      sdi_valid = 1'b1;
      w = 0;
      while (!sdi_ready && w < 8) begin
        step();
        w++;
      end
      if (!sdi_ready) begin
        chk("sdi_ready_timeout", 32'h0, 32'h1);
        sdi_valid = 1'b0;
        return;
      end
      step();
    end
    sdi_valid = 1'b0;
  endtask

  // Independent reference for one complete frame's outcome.
  function automatic exp_t predict(input logic [15:0] key, input logic par);
    exp_t e;
    logic good;
    good = ((^key) ^ par) == 1'b0;
    if (good) begin
      model_fail = 0;
      e.armed = 1'b1; e.err = 1'b0; e.locked = 1'b0; e.key = key;
    end else begin
      model_fail = (model_fail >= 15) ? 15 : model_fail + 1;
      e.armed  = 1'b0;
      e.locked = (model_fail == 3);
      e.err    = !e.locked;
      e.key    = 16'h0000;
    end
    e.fail = 4'(model_fail);
    return e;
  endfunction

  task automatic run_frame(input string tag, input logic [15:0] key, input logic par, input bit gaps);
    int   lat;
    exp_t e;
    start_frame();
    sb.push_back(predict(key, par));
    send_bits(key, par, 17, gaps);
    lat = 1;
    while (!(key_armed || key_err || locked_out) && lat < 8) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 2);
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'h0, 32'h1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_armed"},  key_armed,  e.armed);
    chk({tag, "_err"},    key_err,    e.err);
    chk({tag, "_locked"}, locked_out, e.locked);
    chk({tag, "_key"},    key_out,    e.key);
    chk({tag, "_fail"},   fail_cnt,   e.fail);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; sdi = 1'b0; sdi_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    repeat (10) step();
    check_reset_values("reset");

    // Good frame, then hold stable while armed.
    run_frame("good_a5c3", 16'hA5C3, 1'b0, 1'b0);
    repeat (5) step();
    chk("armed_hold_key", key_out, 32'hA5C3);

    // Three bad frames: error, error, lockout.
    run_frame("bad1", 16'hA5C3, 1'b1, 1'b0);
    run_frame("bad2", 16'hA5C3, 1'b1, 1'b0);
    run_frame("bad3", 16'hA5C3, 1'b1, 1'b0);

    // Lockout ignores frames entirely.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("lock_ready", sdi_ready, 32'h0);
    sdi = 1'b1; sdi_valid = 1'b1;
    repeat (20) step();
    sdi_valid = 1'b0;
    step();
    chk("lock_sticky", locked_out, 32'h1);
    chk("lock_key",    key_out,    32'h0);
    chk("lock_armed",  key_armed,  32'h0);
    chk("lock_fail",   fail_cnt,   32'h3);

    rst = 1'b1;
    step();
    rst = 1'b0;
    model_fail = 0;
    check_reset_values("unlock_rst");

    // Random valid gaps must not disturb the bit count.
    run_frame("gaps_0001", 16'h0001, 1'b1, 1'b1);

    // Abort after 8 bits, then a full good frame.
    start_frame();
    chk("start_drops_armed", key_armed, 32'h0);
    send_bits(16'h3C3C, 1'b0, 8, 1'b0);
    chk("shift_key_decoy", key_out, 32'h0);
    chk("shift_ready",     sdi_ready, 32'h1);
    run_frame("abort_ffff", 16'hFFFF, 1'b0, 1'b0);

    // Reset mid-frame after being armed with FFFF.
    start_frame();
    send_bits(16'h5A5A, 1'b0, 10, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_fail = 0;
    check_reset_values("midframe_rst");
    repeat (3) step();
    chk("post_rst_key",   key_out,   32'h0);
    chk("post_rst_armed", key_armed, 32'h0);

    chk("sb_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
